// File: rtl/data_mem_arb_pkg.sv
// Shared widths and FSM state type for the data-memory arbiter.
package data_mem_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/data_memory_arbiter_rr.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    idx,
  output logic               vld
);
  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    pos   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      pos = (int'(ptr) + off) % NUM_REQ;
      if (!vld && req[pos]) begin
        vld        = 1'b1;
        idx        = IDXW'(pos);
        grant[pos] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_REQ single-beat masters.
module data_memory_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_adr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_adr,
  output logic [DATA_W-1:0]         mem_datain,
  output logic                      mem_w,
  output logic                      mem_r,
  input  logic [DATA_W-1:0]         mem_dataout
);
  localparam int IDXW = (NUM_REQ > 2) ? 2 : 1;
  localparam int CNTW = $clog2(READ_LATENCY + 1);

  arb_state_t         state;
  logic [IDXW-1:0]    ptr;
  logic [IDXW-1:0]    idx;
  logic               we;
  logic [CNTW-1:0]    cnt;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDXW-1:0]    win_idx;
  logic               win_vld;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (win_oh),
    .idx   (win_idx),
    .vld   (win_vld)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      idx        <= '0;
      we         <= 1'b0;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      mem_w      <= 1'b0;
      mem_r      <= 1'b0;
      mem_adr    <= '0;
      mem_datain <= '0;
      rdata      <= '0;
    end else begin
      gnt   <= '0;
      done  <= '0;
      mem_w <= 1'b0;
      mem_r <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            idx        <= win_idx;
            we         <= req_we[win_idx];
            mem_adr    <= req_adr[win_idx*ADDR_W +: ADDR_W];
            mem_datain <= req_wdata[win_idx*DATA_W +: DATA_W];
            mem_w      <= req_we[win_idx];
            mem_r      <= !req_we[win_idx];
            gnt        <= win_oh;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          ptr <= (idx == IDXW'(NUM_REQ - 1)) ? '0 : idx + IDXW'(1);
          cnt <= CNTW'(READ_LATENCY);
          if (we) begin
            done  <= NUM_REQ'(1) << idx;
            state <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNTW'(1);
          // Final wait cycle: memory output is valid now, so capture and respond next cycle.
          if (cnt == CNTW'(1)) begin
            rdata <= mem_dataout;
            done  <= NUM_REQ'(1) << idx;
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
